// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC/IF-ID enables from load-use, mispredict and imem-ready; outputs are Mealy, zero latency.
// Stalls hold the PC while imem is not ready or a load-use hazard exists. Optional FETCH_CTRL_PERF_EN adds stall/flush counters.
module fetch_ctrl #(
  parameter int unsigned REDIRECT_BUBBLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rd,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic       ex_mispredict,
  input  logic       if_predict_taken,
  input  logic       imem_ready,
  output logic       pc_en,
  output logic [1:0] pc_sel,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       fetch_valid,
  output logic [1:0] state
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);

  typedef enum logic [1:0] {
    BOOT      = 2'b00,
    RUN       = 2'b01,
    IMEM_WAIT = 2'b10,
    REDIRECT  = 2'b11
  } state_t;

  localparam logic [1:0] CNT_RELOAD =
    (REDIRECT_BUBBLES > 0) ? 2'(REDIRECT_BUBBLES - 1) : 2'd0;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       lu;

  assign lu = idex_mem_read & (idex_rd != 5'd0) &
              ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_en      = 1'b0;
    pc_sel     = 2'b00;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (state_q == BOOT) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
    end else if (ex_mispredict) begin
      // Redirect wins over everything, including an in-progress memory wait.
      pc_en      = 1'b1;
      pc_sel     = 2'b01;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      cnt_d      = CNT_RELOAD;
      state_d    = (REDIRECT_BUBBLES > 0) ? REDIRECT : RUN;
    end else if (state_q == REDIRECT) begin
      ifid_flush = 1'b1;
      if (cnt_q == 2'd0) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (lu) begin
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!imem_ready) begin
      ifid_flush = 1'b1;
      state_d    = IMEM_WAIT;
    end else begin
      pc_en   = 1'b1;
      pc_sel  = if_predict_taken ? 2'b10 : 2'b00;
      state_d = RUN;
    end
  end

  assign fetch_valid = pc_en & ifid_en & ~ifid_flush;
  assign state       = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_cycles_q, flush_cycles_d;
  logic        stall_now;

  // Stall = load-use or not-ready rule firing, plus every cycle spent in IMEM_WAIT.
  assign stall_now = (state_q == IMEM_WAIT) |
                     ((state_q == RUN) & ~ex_mispredict & (lu | ~imem_ready));

  always_comb begin
    stall_cycles_d = stall_now ? stall_cycles_q + 32'd1 : stall_cycles_q;
    flush_cycles_d = (ifid_flush && state_q != BOOT) ? flush_cycles_q + 32'd1
                                                      : flush_cycles_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 32'd0;
      flush_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with REDIRECT_BUBBLES = 2 and a small PC register model.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       idex_mem_read;
  logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
  logic       ex_mispredict, if_predict_taken, imem_ready;
  logic       pc_en, ifid_en, ifid_flush, idex_flush, fetch_valid;
  logic [1:0] pc_sel, state;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] BR_TGT   = 32'h0000_0100;
  localparam logic [31:0] PRED_TGT = 32'h0000_0200;

  // Output vector: {pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, fetch_valid, state}
  localparam logic [8:0] O_BOOT   = 9'b0_00_1_1_1_0_00;
  localparam logic [8:0] O_RUN    = 9'b1_00_1_0_0_1_01;
  localparam logic [8:0] O_TAKEN  = 9'b1_10_1_0_0_1_01;
  localparam logic [8:0] O_LU     = 9'b0_00_0_0_1_0_01;
  localparam logic [8:0] O_MISP   = 9'b1_01_1_1_1_0_01;
  localparam logic [8:0] O_REDIR  = 9'b0_00_1_1_0_0_11;
  localparam logic [8:0] O_MISP_R = 9'b1_01_1_1_1_0_11;
  localparam logic [8:0] O_NRDY   = 9'b0_00_1_1_0_0_01;
  localparam logic [8:0] O_WAIT   = 9'b0_00_1_1_0_0_10;
  localparam logic [8:0] O_WAITOK = 9'b1_00_1_0_0_1_10;
  localparam logic [8:0] O_MISP_W = 9'b1_01_1_1_1_0_10;

  logic [8:0]  outs;
  logic [31:0] pc;
  assign outs = {pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, fetch_valid, state};

  always #5 clk = ~clk;

  // Stand-in for register_pc, steered by the DUT's enable and mux select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= 32'h0;
    else if (pc_en) begin
      case (pc_sel)
        2'b01:   pc <= BR_TGT;
        2'b10:   pc <= PRED_TGT;
        default: pc <= pc + 32'd4;
      endcase
    end
  end

  fetch_ctrl #(.REDIRECT_BUBBLES(2)) dut (
    .clk(clk), .rst(rst),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ex_mispredict(ex_mispredict), .if_predict_taken(if_predict_taken),
    .imem_ready(imem_ready),
    .pc_en(pc_en), .pc_sel(pc_sel), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .fetch_valid(fetch_valid), .state(state)
`ifdef FETCH_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
  );

  // Inputs change on the falling edge; checks run 1ns later, far from the rising edge.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    idex_mem_read = 1'b0; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
    ex_mispredict = 1'b0; if_predict_taken = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    tests++; if (outs !== O_BOOT) begin fails++; $display("FAIL reset_hold: outs=%b exp=%b", outs, O_BOOT); end
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc: pc=%h exp=%h", pc, 32'h0); end
    @(negedge clk); rst = 1'b1; #1;
    tests++; if (outs !== O_BOOT) begin fails++; $display("FAIL boot_after_release: outs=%b exp=%b", outs, O_BOOT); end
    next_cycle();
    tests++; if (outs !== O_RUN) begin fails++; $display("FAIL first_run: outs=%b exp=%b", outs, O_RUN); end
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL pc_edge1: pc=%h exp=%h", pc, 32'h0); end
    next_cycle();
    tests++; if (pc !== 32'h4) begin fails++; $display("FAIL pc_edge2: pc=%h exp=%h", pc, 32'h4); end
    next_cycle();
    tests++; if (pc !== 32'h8) begin fails++; $display("FAIL pc_edge3: pc=%h exp=%h", pc, 32'h8); end
  endtask

  task automatic test_load_use();
    next_cycle();                                   // pc = 0xC
    idex_mem_read = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5; #1;
    tests++; if (outs !== O_LU) begin fails++; $display("FAIL lu_rs2: outs=%b exp=%b", outs, O_LU); end
    next_cycle();
    idex_mem_read = 1'b0; #1;
    tests++; if (outs !== O_RUN) begin fails++; $display("FAIL lu_one_cycle: outs=%b exp=%b", outs, O_RUN); end
    tests++; if (pc !== 32'hC) begin fails++; $display("FAIL lu_pc_hold: pc=%h exp=%h", pc, 32'hC); end
    next_cycle();                                   // pc = 0x10
    idex_mem_read = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; #1;
    tests++; if (outs !== O_RUN) begin fails++; $display("FAIL lu_rd_zero: outs=%b exp=%b", outs, O_RUN); end
    next_cycle();                                   // pc = 0x14
    idex_rd = 5'd7; ifid_rs1 = 5'd7; ifid_rs2 = 5'd3; #1;
    tests++; if (outs !== O_LU) begin fails++; $display("FAIL lu_rs1: outs=%b exp=%b", outs, O_LU); end
    next_cycle();
    idle_inputs(); #1;
    tests++; if (pc !== 32'h14) begin fails++; $display("FAIL lu_rs1_pc_hold: pc=%h exp=%h", pc, 32'h14); end
  endtask

  task automatic test_mispredict();
    next_cycle();
    ex_mispredict = 1'b1; #1;
    tests++; if (outs !== O_MISP) begin fails++; $display("FAIL misp_cycle: outs=%b exp=%b", outs, O_MISP); end
    next_cycle();
    ex_mispredict = 1'b0; #1;
    tests++; if (outs !== O_REDIR) begin fails++; $display("FAIL redirect_1: outs=%b exp=%b", outs, O_REDIR); end
    tests++; if (pc !== BR_TGT) begin fails++; $display("FAIL redirect_pc: pc=%h exp=%h", pc, BR_TGT); end
    next_cycle();
    tests++; if (outs !== O_REDIR) begin fails++; $display("FAIL redirect_2: outs=%b exp=%b", outs, O_REDIR); end
    next_cycle();
    tests++; if (outs !== O_RUN) begin fails++; $display("FAIL redirect_resume: outs=%b exp=%b", outs, O_RUN); end
    tests++; if (pc !== BR_TGT) begin fails++; $display("FAIL redirect_pc_frozen: pc=%h exp=%h", pc, BR_TGT); end
    next_cycle();
    if_predict_taken = 1'b1; #1;
    tests++; if (pc !== BR_TGT + 32'd4) begin fails++; $display("FAIL post_redirect_pc: pc=%h exp=%h", pc, BR_TGT + 32'd4); end
    tests++; if (outs !== O_TAKEN) begin fails++; $display("FAIL predict_taken: outs=%b exp=%b", outs, O_TAKEN); end
    next_cycle();
    if_predict_taken = 1'b0; #1;
    tests++; if (pc !== PRED_TGT) begin fails++; $display("FAIL predict_pc: pc=%h exp=%h", pc, PRED_TGT); end
  endtask

  task automatic test_imem_wait();
    next_cycle();                                   // pc = 0x204
    imem_ready = 1'b0; #1;
    tests++; if (outs !== O_NRDY) begin fails++; $display("FAIL nrdy_run: outs=%b exp=%b", outs, O_NRDY); end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      tests++; if (outs !== O_WAIT) begin fails++; $display("FAIL imem_wait_%0d: outs=%b exp=%b", i, outs, O_WAIT); end
    end
    tests++; if (pc !== 32'h204) begin fails++; $display("FAIL wait_pc_frozen: pc=%h exp=%h", pc, 32'h204); end
    next_cycle();
    imem_ready = 1'b1; #1;
    tests++; if (outs !== O_WAITOK) begin fails++; $display("FAIL wait_release: outs=%b exp=%b", outs, O_WAITOK); end
    next_cycle();
    tests++; if (outs !== O_RUN) begin fails++; $display("FAIL wait_to_run: outs=%b exp=%b", outs, O_RUN); end
    tests++; if (pc !== 32'h208) begin fails++; $display("FAIL wait_pc_advance: pc=%h exp=%h", pc, 32'h208); end
  endtask

  task automatic test_collisions();
    // Mispredict together with a load-use hazard: redirect, no stall.
    next_cycle();
    ex_mispredict = 1'b1; idex_mem_read = 1'b1; idex_rd = 5'd9; ifid_rs1 = 5'd9; #1;
    tests++; if (outs !== O_MISP) begin fails++; $display("FAIL misp_vs_lu: outs=%b exp=%b", outs, O_MISP); end
    next_cycle();
    idle_inputs(); #1;
    tests++; if (outs !== O_REDIR) begin fails++; $display("FAIL misp_vs_lu_redirect: outs=%b exp=%b", outs, O_REDIR); end
    next_cycle();
    next_cycle();
    tests++; if (outs !== O_RUN) begin fails++; $display("FAIL misp_vs_lu_resume: outs=%b exp=%b", outs, O_RUN); end
    // Mispredict together with imem not ready: no IMEM_WAIT entry.
    ex_mispredict = 1'b1; imem_ready = 1'b0; #1;
    tests++; if (outs !== O_MISP) begin fails++; $display("FAIL misp_vs_nrdy: outs=%b exp=%b", outs, O_MISP); end
    next_cycle();
    idle_inputs(); #1;
    tests++; if (outs !== O_REDIR) begin fails++; $display("FAIL misp_vs_nrdy_state: outs=%b exp=%b", outs, O_REDIR); end
    next_cycle();
    next_cycle();
    // Mispredict while in IMEM_WAIT abandons the wait.
    imem_ready = 1'b0; #1;
    next_cycle();
    ex_mispredict = 1'b1; #1;
    tests++; if (outs !== O_MISP_W) begin fails++; $display("FAIL misp_in_wait: outs=%b exp=%b", outs, O_MISP_W); end
    next_cycle();
    idle_inputs(); #1;
    tests++; if (outs !== O_REDIR) begin fails++; $display("FAIL wait_exit_redirect: outs=%b exp=%b", outs, O_REDIR); end
    // Asynchronous reset in the middle of REDIRECT.
    #2 rst = 1'b0; #1;
    tests++; if (outs !== O_BOOT) begin fails++; $display("FAIL async_reset: outs=%b exp=%b", outs, O_BOOT); end
    @(negedge clk); rst = 1'b1; #1;
    tests++; if (outs !== O_BOOT) begin fails++; $display("FAIL reset_boot_again: outs=%b exp=%b", outs, O_BOOT); end
    next_cycle();
    tests++; if (outs !== O_RUN) begin fails++; $display("FAIL reset_run_again: outs=%b exp=%b", outs, O_RUN); end
  endtask

  task automatic test_back_to_back();
    // Second mispredict on the last REDIRECT cycle reloads the counter.
    next_cycle();
    ex_mispredict = 1'b1; #1;
    next_cycle();
    ex_mispredict = 1'b0; #1;
    next_cycle();
    ex_mispredict = 1'b1; #1;
    tests++; if (outs !== O_MISP_R) begin fails++; $display("FAIL misp_in_redirect: outs=%b exp=%b", outs, O_MISP_R); end
    next_cycle();
    ex_mispredict = 1'b0; #1;
    tests++; if (outs !== O_REDIR) begin fails++; $display("FAIL reload_1: outs=%b exp=%b", outs, O_REDIR); end
    next_cycle();
    tests++; if (outs !== O_REDIR) begin fails++; $display("FAIL reload_2: outs=%b exp=%b", outs, O_REDIR); end
    next_cycle();
    tests++; if (outs !== O_RUN) begin fails++; $display("FAIL reload_resume: outs=%b exp=%b", outs, O_RUN); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mispredict();
    test_imem_wait();
    test_collisions();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
